// File: rtl/veritune_mem_sched.sv
// veritune_mem_sched: frame scheduler for the shared FFT1024 sample RAM.
// Each frame goes through capture, then the FFT runs in place, then the host reads out.
//
// Ports:
//   Clk, Reset (async, active-low)
//   Arm                           frame start pulse
//   Smp_valid/Smp_data/Smp_ready  capture handshake
//   Mem_we/Mem_addr/Mem_wdata     RAM write port, capture phase only
//   Mem_sel                       RAM owner: 00 cap, 01 fft, 10 host, 11 none
//   Fft_start/Fft_ack/Fft_done    FFT1024 handshake
//   Rd_gnt/Rd_done                host readout handshake
//   Frame_ready                   FFT result valid in RAM
//   Overrun, Timeout              sticky error flags, cleared by Arm
//   State                         debug state code
//
// Build option: define VERITUNE_BITREV_EN to write each capture at the
// bit-reversed address. Without it, captures are written in natural order.
module veritune_mem_sched #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int FFT_TIMEOUT = 65535
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Arm,
  input  logic              Smp_valid,
  input  logic [DATA_W-1:0] Smp_data,
  output logic              Smp_ready,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [DATA_W-1:0] Mem_wdata,
  output logic [1:0]        Mem_sel,
  output logic              Fft_start,
  output logic              Fft_ack,
  input  logic              Fft_done,
  output logic              Rd_gnt,
  input  logic              Rd_done,
  output logic              Frame_ready,
  output logic              Overrun,
  output logic              Timeout,
  output logic [2:0]        State
);

  localparam int N  = 2 ** ADDR_W;
  localparam int TW = $clog2(FFT_TIMEOUT + 1);

  localparam logic [ADDR_W:0] CNT_LAST =
    (ADDR_W+1)'(N - 1);
  localparam logic [TW-1:0] TMR_LAST =
    TW'(FFT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CAPTURE  = 3'd1,
    S_FFT_GO   = 3'd2,
    S_FFT_WAIT = 3'd3,
    S_READOUT  = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   wr_cnt;
  logic [TW-1:0]     timer;
  logic              accept;
  logic              fft_own;
  logic [ADDR_W-1:0] addr_nat;
  logic [ADDR_W-1:0] addr_map;

  assign Smp_ready = (state == S_CAPTURE);
  assign accept    = Smp_ready && Smp_valid;
  assign fft_own   = (state == S_FFT_GO) ||
                     (state == S_FFT_WAIT);
  assign addr_nat  = wr_cnt[ADDR_W-1:0];
  assign State     = state;

`ifdef VERITUNE_BITREV_EN
  always_comb begin
    addr_map = '0;
    for (int i = 0; i < ADDR_W; i++)
      addr_map[i] = addr_nat[ADDR_W-1-i];
  end
`else
  assign addr_map = addr_nat;
`endif

  always_comb begin
    Mem_sel = 2'b11;
    unique case (1'b1)
      state == S_CAPTURE: Mem_sel = 2'b00;
      fft_own:            Mem_sel = 2'b01;
      state == S_READOUT: Mem_sel = 2'b10;
      default:            Mem_sel = 2'b11;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= S_IDLE;
      wr_cnt      <= '0;
      timer       <= '0;
      Mem_we      <= 1'b0;
      Mem_addr    <= '0;
      Mem_wdata   <= '0;
      Fft_start   <= 1'b0;
      Fft_ack     <= 1'b0;
      Rd_gnt      <= 1'b0;
      Frame_ready <= 1'b0;
      Overrun     <= 1'b0;
      Timeout     <= 1'b0;
    end else begin
      Mem_we    <= 1'b0;
      Fft_start <= 1'b0;
      Fft_ack   <= 1'b0;

      // The FFT owns the RAM, so this sample is lost.
      if (fft_own && Smp_valid)
        Overrun <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (Arm) begin
            state   <= S_CAPTURE;
            wr_cnt  <= '0;
            Overrun <= 1'b0;
            Timeout <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (accept) begin
            Mem_we    <= 1'b1;
            Mem_addr  <= addr_map;
            Mem_wdata <= Smp_data;
            wr_cnt    <= wr_cnt + 1'b1;
            // Raise start now so that it is high during FFT_GO.
            if (wr_cnt == CNT_LAST) begin
              state     <= S_FFT_GO;
              Fft_start <= 1'b1;
            end
          end
        end
        S_FFT_GO: begin
          timer <= '0;
          state <= S_FFT_WAIT;
        end
        S_FFT_WAIT: begin
          // timer counts completed wait cycles.
          // Done has priority over the timeout.
          if (Fft_done) begin
            state       <= S_READOUT;
            Fft_ack     <= 1'b1;
            Frame_ready <= 1'b1;
            Rd_gnt      <= 1'b1;
          end else if (timer == TMR_LAST) begin
            state   <= S_ERR;
            Timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_READOUT: begin
          if (Arm) begin
            state       <= S_CAPTURE;
            wr_cnt      <= '0;
            Frame_ready <= 1'b0;
            Rd_gnt      <= 1'b0;
            Overrun     <= 1'b0;
            Timeout     <= 1'b0;
          end else if (Rd_done) begin
            state       <= S_IDLE;
            Frame_ready <= 1'b0;
            Rd_gnt      <= 1'b0;
          end
        end
        S_ERR: begin
          if (Arm) begin
            state   <= S_CAPTURE;
            wr_cnt  <= '0;
            Overrun <= 1'b0;
            Timeout <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_veritune_mem_sched.sv
// tb_veritune_mem_sched: randomized capture/FFT/readout scenarios
// checked against a frame-level reference model.
module tb_veritune_mem_sched;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int TO = 100;
  localparam int N  = 1 << AW;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Arm = 1'b0;
  logic          Smp_valid = 1'b0;
  logic [DW-1:0] Smp_data = '0;
  logic          Fft_done = 1'b0;
  logic          Rd_done = 1'b0;
  logic          Smp_ready;
  logic          Mem_we;
  logic [AW-1:0] Mem_addr;
  logic [DW-1:0] Mem_wdata;
  logic [1:0]    Mem_sel;
  logic          Fft_start;
  logic          Fft_ack;
  logic          Rd_gnt;
  logic          Frame_ready;
  logic          Overrun;
  logic          Timeout;
  logic [2:0]    State;

  int vec  = 0;
  int errs = 0;

  veritune_mem_sched #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .FFT_TIMEOUT(TO)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Arm(Arm),
    .Smp_valid(Smp_valid),
    .Smp_data(Smp_data),
    .Smp_ready(Smp_ready),
    .Mem_we(Mem_we),
    .Mem_addr(Mem_addr),
    .Mem_wdata(Mem_wdata),
    .Mem_sel(Mem_sel),
    .Fft_start(Fft_start),
    .Fft_ack(Fft_ack),
    .Fft_done(Fft_done),
    .Rd_gnt(Rd_gnt),
    .Rd_done(Rd_done),
    .Frame_ready(Frame_ready),
    .Overrun(Overrun),
    .Timeout(Timeout),
    .State(State)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference address of the k-th sample in a frame.
  function automatic logic [AW-1:0] ref_addr(int k);
    int r;
    r = k % N;
`ifdef VERITUNE_BITREV_EN
    r = 0;
    for (int i = 0; i < AW; i++)
      r = r * 2 + ((k >> i) & 1);
`endif
    return AW'(r);
  endfunction

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic arm_pulse();
    Arm = 1'b1;
    tick();
    Arm = 1'b0;
  endtask

  // Stream one full frame back to back.
  task automatic fill_frame();
    Smp_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      Smp_data = DW'($urandom);
      tick();
    end
    Smp_valid = 1'b0;
    vec++;
    if (State !== 3'd2 || Fft_start !== 1'b1) begin
      errs++;
      $display("FAIL fill_go state=%0d start=%b want 2/1",
               State, Fft_start);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick();
    tick();
    vec++;
    if (State !== 3'd0 || Mem_sel !== 2'b11 ||
        Smp_ready !== 1'b0 || Mem_we !== 1'b0) begin
      errs++;
      $display("FAIL rst_ctl state=%0d sel=%b rdy=%b we=%b want 0/11/0/0",
               State, Mem_sel, Smp_ready, Mem_we);
    end
    vec++;
    if ({Fft_start, Fft_ack, Rd_gnt, Frame_ready,
         Overrun, Timeout} !== 6'b0 ||
        Mem_addr !== '0 || Mem_wdata !== '0) begin
      errs++;
      $display("FAIL rst_out flags=%b addr=%0d data=%0h want 0",
               {Fft_start, Fft_ack, Rd_gnt, Frame_ready,
                Overrun, Timeout}, Mem_addr, Mem_wdata);
    end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_idle_ignore();
    Smp_valid = 1'b1;
    Smp_data  = 16'h1234;
    tick();
    Smp_valid = 1'b0;
    vec++;
    if (State !== 3'd0 || Mem_we !== 1'b0 ||
        Overrun !== 1'b0) begin
      errs++;
      $display("FAIL idle_ign state=%0d we=%b ovr=%b want 0/0/0",
               State, Mem_we, Overrun);
    end
  endtask

  task automatic test_capture();
    int k;
    int cyc;
    logic v;
    logic [DW-1:0] d;
    k   = 0;
    cyc = 0;
    arm_pulse();
    vec++;
    if (State !== 3'd1 || Mem_sel !== 2'b00 ||
        Smp_ready !== 1'b1) begin
      errs++;
      $display("FAIL cap_arm state=%0d sel=%b rdy=%b want 1/00/1",
               State, Mem_sel, Smp_ready);
    end
    while (k < N && cyc < 4 * N) begin
      v = ($urandom_range(0, 2) != 0);
      d = DW'($urandom);
      Arm       = ($urandom_range(0, 15) == 0);
      Smp_valid = v;
      Smp_data  = d;
      vec++;
      if (Smp_ready !== 1'b1 || State !== 3'd1) begin
        errs++;
        $display("FAIL cap_rdy k=%0d rdy=%b state=%0d want 1/1",
                 k, Smp_ready, State);
      end
      tick();
      cyc++;
      vec++;
      if (v) begin
        if (Mem_we !== 1'b1 || Mem_addr !== ref_addr(k) ||
            Mem_wdata !== d) begin
          errs++;
          $display("FAIL cap_wr k=%0d we=%b addr=%0d data=%0h want 1/%0d/%0h",
                   k, Mem_we, Mem_addr, Mem_wdata, ref_addr(k), d);
        end
        k++;
      end else if (Mem_we !== 1'b0) begin
        errs++;
        $display("FAIL cap_idle k=%0d we=%b want 0", k, Mem_we);
      end
    end
    Arm       = 1'b0;
    Smp_valid = 1'b0;
    vec++;
    if (k != N) begin
      errs++;
      $display("FAIL cap_budget accepted=%0d want %0d", k, N);
    end
    vec++;
    if (State !== 3'd2 || Fft_start !== 1'b1 ||
        Mem_sel !== 2'b01) begin
      errs++;
      $display("FAIL fft_go state=%0d start=%b sel=%b want 2/1/01",
               State, Fft_start, Mem_sel);
    end
  endtask

  // Done arrives 50 cycles after the start pulse; one stray
  // sample is offered while waiting.
  task automatic test_fft_done();
    for (int n = 1; n < 50; n++) begin
      Smp_valid = (n == 10);
      tick();
      vec++;
      if (State !== 3'd3 || Fft_start !== 1'b0 ||
          Mem_we !== 1'b0 || Mem_sel !== 2'b01) begin
        errs++;
        $display("FAIL wait n=%0d state=%0d start=%b we=%b sel=%b want 3/0/0/01",
                 n, State, Fft_start, Mem_we, Mem_sel);
      end
      if (n == 10) begin
        vec++;
        if (Overrun !== 1'b1) begin
          errs++;
          $display("FAIL overrun got=%b want 1", Overrun);
        end
      end
    end
    Smp_valid = 1'b0;
    Fft_done  = 1'b1;
    tick();
    Fft_done  = 1'b0;
    vec++;
    if (State !== 3'd4 || Fft_ack !== 1'b1 ||
        Frame_ready !== 1'b1 || Rd_gnt !== 1'b1 ||
        Mem_sel !== 2'b10) begin
      errs++;
      $display("FAIL done state=%0d ack=%b fr=%b gnt=%b sel=%b want 4/1/1/1/10",
               State, Fft_ack, Frame_ready, Rd_gnt, Mem_sel);
    end
    tick();
    vec++;
    if (Fft_ack !== 1'b0 || State !== 3'd4 ||
        Overrun !== 1'b1) begin
      errs++;
      $display("FAIL ack_pulse ack=%b state=%0d ovr=%b want 0/4/1",
               Fft_ack, State, Overrun);
    end
  endtask

  task automatic test_rd_done();
    Rd_done = 1'b1;
    tick();
    Rd_done = 1'b0;
    vec++;
    if (State !== 3'd0 || Frame_ready !== 1'b0 ||
        Rd_gnt !== 1'b0 || Mem_sel !== 2'b11 ||
        Overrun !== 1'b1) begin
      errs++;
      $display("FAIL rd_done state=%0d fr=%b gnt=%b sel=%b ovr=%b want 0/0/0/11/1",
               State, Frame_ready, Rd_gnt, Mem_sel, Overrun);
    end
    arm_pulse();
    vec++;
    if (State !== 3'd1 || Overrun !== 1'b0) begin
      errs++;
      $display("FAIL ovr_clr state=%0d ovr=%b want 1/0",
               State, Overrun);
    end
  endtask

  // The FFT never answers: the wait lasts TO cycles.
  task automatic test_timeout();
    int w;
    w = 0;
    fill_frame();
    do begin
      tick();
      if (State === 3'd3) w++;
    end while (State === 3'd3 && w < 4 * TO);
    vec++;
    if (w != TO) begin
      errs++;
      $display("FAIL to_len wait=%0d want %0d", w, TO);
    end
    vec++;
    if (State !== 3'd5 || Timeout !== 1'b1 ||
        Mem_sel !== 2'b11 || Fft_ack !== 1'b0) begin
      errs++;
      $display("FAIL to_err state=%0d to=%b sel=%b ack=%b want 5/1/11/0",
               State, Timeout, Mem_sel, Fft_ack);
    end
    arm_pulse();
    vec++;
    if (State !== 3'd1 || Timeout !== 1'b0) begin
      errs++;
      $display("FAIL to_clr state=%0d to=%b want 1/0",
               State, Timeout);
    end
  endtask

  // Done in the last allowed wait cycle beats the timeout.
  task automatic test_done_at_limit();
    fill_frame();
    for (int n = 0; n < TO; n++) tick();
    vec++;
    if (State !== 3'd3) begin
      errs++;
      $display("FAIL lim_wait state=%0d want 3", State);
    end
    Fft_done = 1'b1;
    tick();
    Fft_done = 1'b0;
    vec++;
    if (State !== 3'd4 || Timeout !== 1'b0 ||
        Fft_ack !== 1'b1) begin
      errs++;
      $display("FAIL lim_done state=%0d to=%b ack=%b want 4/0/1",
               State, Timeout, Fft_ack);
    end
  endtask

  // Arm and Rd_done together: Arm wins and the count restarts.
  task automatic test_arm_rd_done();
    logic [DW-1:0] d;
    Arm     = 1'b1;
    Rd_done = 1'b1;
    tick();
    Arm     = 1'b0;
    Rd_done = 1'b0;
    vec++;
    if (State !== 3'd1 || Frame_ready !== 1'b0 ||
        Rd_gnt !== 1'b0 || Mem_sel !== 2'b00) begin
      errs++;
      $display("FAIL arm_rd state=%0d fr=%b gnt=%b sel=%b want 1/0/0/00",
               State, Frame_ready, Rd_gnt, Mem_sel);
    end
    for (int k = 0; k < 3; k++) begin
      d = DW'($urandom);
      Smp_valid = 1'b1;
      Smp_data  = d;
      tick();
      vec++;
      if (Mem_we !== 1'b1 || Mem_addr !== ref_addr(k) ||
          Mem_wdata !== d) begin
        errs++;
        $display("FAIL restart k=%0d we=%b addr=%0d data=%0h want 1/%0d/%0h",
                 k, Mem_we, Mem_addr, Mem_wdata, ref_addr(k), d);
      end
    end
  endtask

  // Reset dropped in the middle of a capture.
  task automatic test_reset_mid();
    Smp_valid = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    vec++;
    if (State !== 3'd0 || Mem_sel !== 2'b11 ||
        Smp_ready !== 1'b0 || Mem_we !== 1'b0) begin
      errs++;
      $display("FAIL rst_async state=%0d sel=%b rdy=%b we=%b want 0/11/0/0",
               State, Mem_sel, Smp_ready, Mem_we);
    end
    tick();
    vec++;
    if (State !== 3'd0 || Mem_sel !== 2'b11 ||
        Smp_ready !== 1'b0 || Mem_we !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid state=%0d sel=%b rdy=%b we=%b want 0/11/0/0",
               State, Mem_sel, Smp_ready, Mem_we);
    end
    Smp_valid = 1'b0;
    Reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_capture();
    tick();
    test_fft_done();
    test_rd_done();
    test_timeout();
    test_done_at_limit();
    test_arm_rd_done();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
